sample_window: RTL and testbench
================================

# sample_window

Windowed, hysteretic phase sampler for the Ising array. It is the parametrised successor of the free-running spin/local-field phase sampler. Per channel it synchronises the spin (`outputs_ver`) and local-field (`outputs_hor`) oscillator outputs and integrates their agreement in a saturating up/down counter over a software-defined window. It then resolves an in/out-of-phase decision with hysteresis and reports completion with a `start`/`done` handshake. It sits between the coupled oscillator array and the readout/annealing controller.

## Interface
- `N`, 3, number of spin channels
- `W`, 16, counter width (bits); all thresholds use the same width
- `clk`  in  1  sole clock
- `rstn`  in  1  reset: synchronous, active-low
- `start`  in  1  begin a sampling window; accepted only in IDLE
- `abort`  in  1  terminate a running window without `done`
- `window_len`  in  32  samples per window
- `counter_max`  in  W  counter saturation ceiling
- `counter_cutoff`  in  W  decision threshold and counter preset
- `hysteresis`  in  W  half-width of the decision dead band
- `outputs_ver`  in  N  spin oscillator outputs (asynchronous)
- `outputs_hor`  in  N  local-field oscillator outputs (asynchronous)
- `phase`  out  N  1 = in phase with local field, 0 = out of phase (registered)
- `toggled`  out  N  sticky: `phase[i]` changed during the current/last window
- `busy`  out  1  window in progress
- `done`  out  1  single-cycle pulse: window complete, `phase`/`toggled` final

## Operation
- Sync: each bit of `outputs_ver`/`outputs_hor` passes through a 2-flop synchroniser. `mm[i]` = sync_ver[i] XOR sync_hor[i]. The synchronisers run continuously and are cleared by reset.
- FSM states: IDLE, RUN, DONE.
- IDLE, with `start`=1:
  - cnt[i] <= min(counter_cutoff, counter_max).
  - win <= window_len.
  - toggled <= 0.
  - Next state is RUN if window_len != 0, else DONE.
  - `start` is ignored in RUN and DONE.
- RUN, each cycle:
  - If mm[i] and cnt[i] != 0: cnt[i]-1.
  - Else if !mm[i] and cnt[i] < counter_max: cnt[i]+1.
  - Otherwise cnt[i] holds.
  - phase[i] updates from the pre-update cnt[i] (see Decision).
  - win decrements. If win == 1, next state is DONE.
- DONE (one cycle): phase[i] is evaluated from the final cnt[i]; done <= 1; next state is IDLE.
- Decision, evaluated in RUN and DONE:
  - hi = counter_cutoff + hysteresis, computed at W+1 bits with no wrap.
  - lo = counter_cutoff - hysteresis, floored at 0.
  - cnt >= hi sets phase to 1. cnt < lo sets phase to 0. Otherwise phase holds.
  - Any phase[i] change sets toggled[i].
- `phase` persists across windows and is not re-preset by `start`.
- Abort: `abort`=1 in RUN or DONE forces IDLE next cycle with no `done`. Counters, `phase` and `toggled` keep their values. `abort` in IDLE has no effect, and `abort` takes priority over `start` in the same cycle.
- Counter inputs (`counter_max`, `counter_cutoff`, `hysteresis`, `window_len`) are sampled live; software holds them stable while `busy`=1.

## Timing
- Reset (`rstn`=0 at a clk edge): state IDLE, cnt=0, win=0, synchronisers=0, phase=0, toggled=0, busy=0, done=0. Reset mid-window discards the window with no `done`.
- With `start` accepted at edge t:
  - busy=1 from t+1 until DONE is exited.
  - RUN occupies cycles t+1..t+window_len.
  - DONE occupies cycle t+window_len+1.
  - done=1 and busy=0 in cycle t+window_len+2, with final phase/toggled valid in that same cycle.
- With window_len=0: DONE occupies t+1 and done pulses at t+2.
- A `start` in the done-pulse cycle is accepted, giving back-to-back windows.
- Input-to-counter latency: an input edge is seen by the counter update 2 cycles later (synchroniser). The bench should lead each window by 2 cycles of stimulus.
- `done` is never high for 2 consecutive cycles.

## Test plan
- Reset: drive rstn=0 for 2 cycles during RUN -> phase=0, toggled=0, busy=0, done=0, no done pulse afterward.
- In-phase (N=3, W=8, cutoff=8, max=15, hyst=2, len=20, ver==hor) -> cnt saturates at 15 and holds, phase=3'b111, done exactly at t+22.
- Anti-phase, following the in-phase window (ver=~hor, same settings) -> cnt floors at 0 and holds, phase=3'b000, toggled=3'b111.
- Hysteresis (mm alternating 1,0 per cycle, cutoff=8, hyst=2, len=32, initial phase=1) -> cnt oscillates 7/8, phase stays 1, toggled=0. Repeat with hyst=0 -> phase follows cnt>=8, toggled=1.
- Edge cases:
  - len=0 with cutoff=20, max=15 -> done at t+2, cnt=15.
  - len=1 -> done at t+3.
  - `start` held for 2 cycles -> only one window runs.
- Abort at t+5 of a len=20 window -> busy=0 at t+6, no done, phase/toggled hold. A following `start` then runs normally.

Source files
------------

// File: rtl/sample_window.sv
// sample_window: windowed, hysteretic phase sampler for the Ising array.
// Each channel synchronises its spin (outputs_ver) and local-field
// (outputs_hor) oscillator outputs. It integrates their agreement in a
// saturating up/down counter over a window of window_len samples. It then
// resolves an in/out-of-phase decision with a hysteresis dead band.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start, abort         begin a window (IDLE only) / cancel a running window
//   window_len           samples per window
//   counter_max          counter saturation ceiling
//   counter_cutoff       decision threshold and counter preset
//   hysteresis           half-width of the decision dead band
//   outputs_ver/_hor     asynchronous oscillator outputs, one bit per channel
//   phase                1 = in phase with local field (registered)
//   toggled              sticky per-channel phase-change flag for the window
//   busy, done           window in progress / single-cycle completion pulse
module sample_window #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  window_len,
  input  logic [W-1:0] counter_max,
  input  logic [W-1:0] counter_cutoff,
  input  logic [W-1:0] hysteresis,
  input  logic [N-1:0] outputs_ver,
  input  logic [N-1:0] outputs_hor,
  output logic [N-1:0] phase,
  output logic [N-1:0] toggled,
  output logic         busy,
  output logic         done
);

  localparam int unsigned WL = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  ver_s1;
  logic [N-1:0]  ver_s2;
  logic [N-1:0]  hor_s1;
  logic [N-1:0]  hor_s2;
  logic [N-1:0]  mm;

  logic [W-1:0]  cnt     [N];
  logic [W-1:0]  cnt_nxt [N];
  logic [WL-1:0] win;
  logic [WL-1:0] win_nxt;
  logic [N-1:0]  phase_nxt;
  logic [N-1:0]  toggled_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  logic [W:0]    hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  preset;
  logic          accept;

  // Dead-band decision: set at/above hi, clear below lo, otherwise hold.
  function automatic logic decide(input logic [W-1:0] c, input logic p,
                                  input logic [W:0] h, input logic [W-1:0] l);
    if ({1'b0, c} >= h) return 1'b1;
    if (c < l)          return 1'b0;
    return p;
  endfunction

  // Two-flop synchronisers, free running.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ver_s1 <= '0;
      ver_s2 <= '0;
      hor_s1 <= '0;
      hor_s2 <= '0;
    end else begin
      ver_s1 <= outputs_ver;
      ver_s2 <= ver_s1;
      hor_s1 <= outputs_hor;
      hor_s2 <= hor_s1;
    end
  end

  assign mm     = ver_s2 ^ hor_s2;
  assign accept = start && !abort;

  // Thresholds: hi carries one extra bit so cutoff+hysteresis never wraps.
  always_comb begin
    hi     = {1'b0, counter_cutoff} + {1'b0, hysteresis};
    lo     = (counter_cutoff > hysteresis) ? (counter_cutoff - hysteresis) : '0;
    preset = (counter_cutoff < counter_max) ? counter_cutoff : counter_max;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (window_len != '0) ? RUN : DONE;
      RUN: begin
        if (abort)                 state_nxt = IDLE;
        else if (win == WL'(1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values; abort freezes counters and decisions.
  always_comb begin
    win_nxt     = win;
    phase_nxt   = phase;
    toggled_nxt = toggled;
    done_nxt    = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    for (int i = 0; i < N; i++) cnt_nxt[i] = cnt[i];

    case (state)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < N; i++) cnt_nxt[i] = preset;
          win_nxt     = window_len;
          toggled_nxt = '0;
        end
      end
      RUN: begin
        if (!abort) begin
          for (int i = 0; i < N; i++) begin
            if (mm[i] && (cnt[i] != '0))
              cnt_nxt[i] = cnt[i] - W'(1);
            else if (!mm[i] && (cnt[i] < counter_max))
              cnt_nxt[i] = cnt[i] + W'(1);
            // Decision uses the count before this cycle's update.
            phase_nxt[i] = decide(cnt[i], phase[i], hi, lo);
          end
          win_nxt = win - WL'(1);
        end
      end
      DONE: begin
        if (!abort) begin
          for (int i = 0; i < N; i++) phase_nxt[i] = decide(cnt[i], phase[i], hi, lo);
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    toggled_nxt = toggled_nxt | (phase_nxt ^ phase);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      win     <= '0;
      phase   <= '0;
      toggled <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
      win     <= win_nxt;
      phase   <= phase_nxt;
      toggled <= toggled_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sample_window.sv
// Testbench for sample_window: scenario table, hand-written corner sequences
// and randomized traffic, all checked against a behavioural model.
module tb_sample_window;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         abort;
  logic [31:0]  window_len;
  logic [W-1:0] counter_max;
  logic [W-1:0] counter_cutoff;
  logic [W-1:0] hysteresis;
  logic [N-1:0] outputs_ver;
  logic [N-1:0] outputs_hor;
  logic [N-1:0] phase;
  logic [N-1:0] toggled;
  logic         busy;
  logic         done;

  sample_window #(.N(N), .W(W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .abort          (abort),
    .window_len     (window_len),
    .counter_max    (counter_max),
    .counter_cutoff (counter_cutoff),
    .hysteresis     (hysteresis),
    .outputs_ver    (outputs_ver),
    .outputs_hor    (outputs_hor),
    .phase          (phase),
    .toggled        (toggled),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: per-channel integer counts, samples remaining,
  // and a two-deep delay line of XORed inputs standing in for synchronisers.
  int           m_cnt [N];
  logic [N-1:0] m_ph;
  logic [N-1:0] m_tg;
  int           m_left;
  bit           m_active;     // window accepted and not finished
  bit           m_final;      // next edge is the final evaluation
  bit           m_busy;
  bit           m_done;
  logic [N-1:0] m_d1;
  logic [N-1:0] m_d2;
  bit           prev_done;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic judge(input int c, input logic old, input int hi, input int lo);
    if (c >= hi) return 1'b1;
    if (c < lo)  return 1'b0;
    return old;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ph = '0; m_tg = '0; m_left = 0;
    m_active = 0; m_final = 0; m_busy = 0; m_done = 0;
    m_d1 = '0; m_d2 = '0;
  endtask

  task automatic model_edge(input bit rs, input bit st, input bit ab, input logic [N-1:0] x);
    logic [N-1:0] seen;
    logic         np;
    int           hi, lo, mx;
    seen = m_d2;
    if (!rs) begin
      model_reset();
      return;
    end
    m_d2 = m_d1;
    m_d1 = x;
    hi = int'(counter_cutoff) + int'(hysteresis);
    lo = int'(counter_cutoff) - int'(hysteresis);
    if (lo < 0) lo = 0;
    mx = int'(counter_max);
    m_done = 0;
    if (!m_active) begin
      if (st && !ab) begin
        for (int i = 0; i < N; i++)
          m_cnt[i] = (int'(counter_cutoff) < mx) ? int'(counter_cutoff) : mx;
        m_tg     = '0;
        m_left   = int'(window_len);
        m_active = 1;
        m_final  = (m_left == 0);
      end
    end else if (ab) begin
      m_active = 0;
    end else if (!m_final) begin
      for (int i = 0; i < N; i++) begin
        np = judge(m_cnt[i], m_ph[i], hi, lo);
        if (np != m_ph[i]) m_tg[i] = 1'b1;
        m_ph[i] = np;
        if (seen[i]) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        else         m_cnt[i] = (m_cnt[i] < mx) ? m_cnt[i] + 1 : m_cnt[i];
      end
      m_left--;
      if (m_left == 0) m_final = 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        np = judge(m_cnt[i], m_ph[i], hi, lo);
        if (np != m_ph[i]) m_tg[i] = 1'b1;
        m_ph[i] = np;
      end
      m_done   = 1;
      m_active = 0;
    end
    m_busy = m_active;
  endtask

  task automatic check_cycle();
    logic [2*N+1:0] got;
    logic [2*N+1:0] exp;
    got = {phase, toggled, busy, done};
    exp = {m_ph, m_tg, m_busy, m_done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle t=%0t {phase,toggled,busy,done} got=%b exp=%b", $time, got, exp);
    end
    if (done === 1'b1) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width t=%0t got=2-cycle pulse exp=1-cycle pulse", $time);
      end
    end
    prev_done = (done === 1'b1);
  endtask

  // One clock: apply controls, advance model at the edge, compare just after.
  task automatic step(input logic st, input logic ab, input logic rs);
    start = st; abort = ab; rstn = rs;
    @(posedge clk);
    model_edge(rs, st, ab, outputs_ver ^ outputs_hor);
    #1;
    check_cycle();
  endtask

  // Oscillator patterns: 0 in phase, 1 anti-phase, 2 mm alternating, 3 random.
  task automatic drive(input int pat, input int j);
    logic [N-1:0] r;
    r = N'($urandom);
    case (pat)
      0: begin outputs_ver = r; outputs_hor = r;  end
      1: begin outputs_ver = r; outputs_hor = ~r; end
      2: begin outputs_ver = (j % 2 == 1) ? '1 : '0; outputs_hor = '0; end
      default: begin outputs_ver = r; outputs_hor = N'($urandom); end
    endcase
  endtask

  // Two lead cycles, a start, then enough cycles to finish; reports the
  // edge index (start edge = t, samples taken just after edge t+k count
  // as index k+1) at which done was seen, and how many pulses occurred.
  task automatic run_window(input int pat, output int done_idx, output int ndone);
    int j;
    int idx;
    j = 0; done_idx = -1; ndone = 0;
    for (int k = 0; k < 2; k++) begin drive(pat, j); step(1'b0, 1'b0, 1'b1); j++; end
    drive(pat, j); step(1'b1, 1'b0, 1'b1); j++;
    idx = 1;
    for (int k = 0; k < int'(window_len) + 6; k++) begin
      drive(pat, j); step(1'b0, 1'b0, 1'b1); j++;
      idx++;
      if (done) begin
        ndone++;
        if (done_idx < 0) done_idx = idx;
      end
    end
  endtask

  typedef struct {
    int           cut;
    int           mx;
    int           hy;
    int           len;
    int           pat;
    logic [N-1:0] ph;
    logic [N-1:0] tg;
    int           lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int didx, nd, j, idx, found;
    logic [N-1:0] sv_ph, sv_tg;

    vecs[0] = '{cut: 8,  mx: 15, hy: 2, len: 20, pat: 0, ph: 3'b111, tg: 3'b111, lat: 22};
    vecs[1] = '{cut: 8,  mx: 15, hy: 2, len: 20, pat: 1, ph: 3'b000, tg: 3'b111, lat: 22};
    vecs[2] = '{cut: 8,  mx: 15, hy: 2, len: 20, pat: 0, ph: 3'b111, tg: 3'b111, lat: 22};
    vecs[3] = '{cut: 8,  mx: 15, hy: 2, len: 32, pat: 2, ph: 3'b111, tg: 3'b000, lat: 34};
    vecs[4] = '{cut: 8,  mx: 15, hy: 0, len: 32, pat: 2, ph: 3'b111, tg: 3'b111, lat: 34};
    vecs[5] = '{cut: 20, mx: 15, hy: 0, len: 0,  pat: 0, ph: 3'b000, tg: 3'b111, lat: 2};
    vecs[6] = '{cut: 8,  mx: 15, hy: 2, len: 1,  pat: 0, ph: 3'b000, tg: 3'b000, lat: 3};

    model_reset();
    prev_done = 0;
    start = 0; abort = 0; rstn = 0;
    window_len = 32'd20; counter_max = W'(15); counter_cutoff = W'(8); hysteresis = W'(2);
    outputs_ver = '0; outputs_hor = '0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("reset_phase", phase, 0);
    check("reset_busy", busy, 0);

    // Scenario table.
    foreach (vecs[v]) begin
      counter_cutoff = W'(vecs[v].cut);
      counter_max    = W'(vecs[v].mx);
      hysteresis     = W'(vecs[v].hy);
      window_len     = 32'(vecs[v].len);
      run_window(vecs[v].pat, didx, nd);
      check($sformatf("v%0d_done_at", v), didx, vecs[v].lat);
      check($sformatf("v%0d_ndone", v), nd, 1);
      check($sformatf("v%0d_phase", v), phase, vecs[v].ph);
      check($sformatf("v%0d_toggled", v), toggled, vecs[v].tg);
    end

    // start held for two cycles runs a single window.
    counter_cutoff = W'(8); counter_max = W'(15); hysteresis = W'(2); window_len = 32'd5;
    j = 0;
    for (int k = 0; k < 2; k++) begin drive(0, j); step(1'b0, 1'b0, 1'b1); j++; end
    drive(0, j); step(1'b1, 1'b0, 1'b1); j++;
    drive(0, j); step(1'b1, 1'b0, 1'b1); j++;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      drive(0, j); step(1'b0, 1'b0, 1'b1); j++;
      if (done) nd++;
    end
    check("start_held_ndone", nd, 1);

    // Back-to-back: start in the done-pulse cycle.
    window_len = 32'd3;
    j = 0;
    for (int k = 0; k < 2; k++) begin drive(0, j); step(1'b0, 1'b0, 1'b1); j++; end
    drive(0, j); step(1'b1, 1'b0, 1'b1); j++;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      drive(0, j); step(1'b0, 1'b0, 1'b1); j++;
      if (done) found = 1;
    end
    check("b2b_first_done", found, 1);
    drive(0, j); step(1'b1, 1'b0, 1'b1); j++;
    idx = 1; didx = -1;
    for (int k = 0; k < 12; k++) begin
      drive(0, j); step(1'b0, 1'b0, 1'b1); j++;
      idx++;
      if (done && didx < 0) didx = idx;
    end
    check("b2b_second_done_at", didx, 5);

    // Abort at t+5 of a 20-sample anti-phase window.
    window_len = 32'd20;
    j = 0;
    for (int k = 0; k < 2; k++) begin drive(1, j); step(1'b0, 1'b0, 1'b1); j++; end
    drive(1, j); step(1'b1, 1'b0, 1'b1); j++;
    for (int k = 0; k < 4; k++) begin drive(1, j); step(1'b0, 1'b0, 1'b1); j++; end
    sv_ph = phase; sv_tg = toggled;
    drive(1, j); step(1'b0, 1'b1, 1'b1); j++;
    check("abort_busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      drive(1, j); step(1'b0, 1'b0, 1'b1); j++;
      if (done) nd++;
    end
    check("abort_ndone", nd, 0);
    check("abort_phase_hold", phase, sv_ph);
    check("abort_toggled_hold", toggled, sv_tg);
    window_len = 32'd4;
    run_window(0, didx, nd);
    check("after_abort_done_at", didx, 6);

    // Reset held two cycles in the middle of a window.
    window_len = 32'd20;
    j = 0;
    for (int k = 0; k < 2; k++) begin drive(0, j); step(1'b0, 1'b0, 1'b1); j++; end
    drive(0, j); step(1'b1, 1'b0, 1'b1); j++;
    for (int k = 0; k < 5; k++) begin drive(0, j); step(1'b0, 1'b0, 1'b1); j++; end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("midreset_phase", phase, 0);
    check("midreset_toggled", toggled, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      drive(0, k); step(1'b0, 1'b0, 1'b1);
      if (done) nd++;
    end
    check("midreset_ndone", nd, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (!m_active && $urandom_range(0, 3) == 0) begin
        counter_cutoff = W'($urandom_range(0, 20));
        counter_max    = W'($urandom_range(0, 20));
        hysteresis     = W'($urandom_range(0, 6));
        window_len     = 32'($urandom_range(0, 12));
      end
      drive(3, c);
      step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
